// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Program-counter sequencer for a simple fetch stage. In RUN the PC advances
//   by 4 each cycle, or loads an absolute jump-register target. A taken branch
//   spends one extra cycle in BR_CALC so that the single shared 32-bit adder
//   can form pc+4 in the first cycle and (pc+4)+offset in the second.
//
// Optional feature:
//   PC_ALIGN_CHECK_EN - when defined, jump targets whose low two bits are
//   non-zero are refused (the PC simply advances by 4) and misalign_err
//   pulses for one cycle. When undefined, misalign_err is not a port and
//   jump targets are loaded verbatim.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   stall_i      in   1   hold pc and state this cycle
//   br_req       in   1   taken-branch request (ignored while busy)
//   br_imm       in  16   signed branch word offset
//   jr_req       in   1   jump-register request (ignored while busy)
//   jr_target    in  32   absolute jump target
//   pc           out 32   current fetch address
//   pc_valid     out  1   pc is a committed fetch address this cycle
//   busy         out  1   branch target computation in progress
//   misalign_err out  1   one-cycle misaligned-jump flag (PC_ALIGN_CHECK_EN)
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_req,
    input  logic [15:0] br_imm,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        busy
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        BR_CALC = 1'b1
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_q;
    logic [31:0] pc4_d;
    logic [31:0] off_q;
    logic [31:0] off_d;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] sum;
    logic        started;
`ifdef PC_ALIGN_CHECK_EN
    logic        err_d;
`endif

    // The one adder in the block; its operands are steered by state so that
    // sequential increment and branch-target formation share it. Carry-out
    // is dropped, giving modulo 2^32 wrap.
    always_comb begin
        add_a = pc;
        add_b = 32'd4;
        if (state == BR_CALC) begin
            add_a = pc4_q;
            add_b = off_q;
        end
    end

    assign sum = add_a + add_b;

    // Next-state and output logic. Everything holds by default, which covers
    // stall_i in both states.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        pc4_d    = pc4_q;
        off_d    = off_q;
        busy     = (state == BR_CALC);
        pc_valid = started && (state == RUN);
`ifdef PC_ALIGN_CHECK_EN
        err_d    = 1'b0;
`endif
        unique case (state)
            RUN: begin
                if (!stall_i) begin
                    if (jr_req) begin
`ifdef PC_ALIGN_CHECK_EN
                        if (jr_target[1:0] != 2'b00) begin
                            pc_d  = sum;
                            err_d = 1'b1;
                        end else begin
                            pc_d = jr_target;
                        end
`else
                        pc_d = jr_target;
`endif
                    end else if (br_req) begin
                        // First branch cycle: the adder yields pc+4; the
                        // word offset is sign-extended and scaled to bytes.
                        pc4_d   = sum;
                        off_d   = {{14{br_imm[15]}}, br_imm, 2'b00};
                        state_d = BR_CALC;
                    end else begin
                        pc_d = sum;
                    end
                end
            end
            BR_CALC: begin
                if (!stall_i) begin
                    pc_d    = sum;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any branch in flight.
    // 'started' keeps pc_valid low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pc      <= RESET_PC;
            pc4_q   <= 32'd0;
            off_q   <= 32'd0;
            started <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            pc4_q   <= pc4_d;
            off_q   <= off_d;
            started <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            misalign_err <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Purpose:
//   Self-checking bench for pc_sequencer. A behavioural model tracks the
//   expected PC, a pending branch target and the valid/busy/error flags;
//   directed steps cover the documented scenarios, followed by random traffic.
//   Honours PC_ALIGN_CHECK_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        br_req;
    logic [15:0] br_imm;
    logic        jr_req;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic        pc_valid;
    logic        busy;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (stall_i),
        .br_req    (br_req),
        .br_imm    (br_imm),
        .jr_req    (jr_req),
        .jr_target (jr_target),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .busy      (busy)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_target;
    bit          m_busy;
    bit          m_started;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic modelReset();
        m_pc      = RESET_PC;
        m_target  = 32'd0;
        m_busy    = 1'b0;
        m_started = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, " pc"}, pc, m_pc);
        check({tag, " busy"}, 32'(busy), 32'(m_busy));
        check({tag, " pc_valid"}, 32'(pc_valid), 32'(m_started && !m_busy));
`ifdef PC_ALIGN_CHECK_EN
        check({tag, " misalign_err"}, 32'(misalign_err), 32'(m_err));
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the documented rules,
    // take the clock edge and compare just after it.
    task automatic applyStimulus(input bit s, input bit b, input logic [15:0] imm,
                                 input bit j, input logic [31:0] t, input string tag);
        int          off;
        logic [31:0] n_pc;
        logic [31:0] n_target;
        bit          n_busy;
        bit          n_err;
        stall_i   = s;
        br_req    = b;
        br_imm    = imm;
        jr_req    = j;
        jr_target = t;
        n_pc      = m_pc;
        n_target  = m_target;
        n_busy    = m_busy;
        n_err     = 1'b0;
        if (m_busy) begin
            if (!s) begin
                n_pc   = m_target;
                n_busy = 1'b0;
            end
        end else if (!s) begin
            if (j) begin
`ifdef PC_ALIGN_CHECK_EN
                if (t % 4 != 0) begin
                    n_pc  = m_pc + 32'd4;
                    n_err = 1'b1;
                end else begin
                    n_pc = t;
                end
`else
                n_pc = t;
`endif
            end else if (b) begin
                off      = int'($signed(imm));
                n_target = m_pc + 32'd4 + 32'(off * 4);
                n_busy   = 1'b1;
            end else begin
                n_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        m_pc      = n_pc;
        m_target  = n_target;
        m_busy    = n_busy;
        m_err     = n_err;
        m_started = 1'b1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 32'h0, tag);
    endtask

    task automatic jumpTo(input logic [31:0] t);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, t, "jump");
    endtask

    bit          r_s;
    bit          r_b;
    bit          r_j;
    logic [15:0] r_imm;
    logic [31:0] r_t;

    initial begin
        rst_n     = 1'b0;
        stall_i   = 1'b0;
        br_req    = 1'b0;
        br_imm    = 16'h0;
        jr_req    = 1'b0;
        jr_target = 32'h0;
        modelReset();
        #2;
        checkOutput("reset");
        #10;
        rst_n = 1'b1;
        #1;
        checkOutput("release");

        // Sequential fetch after reset
        idle("seq1");
        check("seq1 valid const", 32'(pc_valid), 32'd1);
        idle("seq2");
        idle("seq3");
        idle("seq4");
        check("seq4 pc const", pc, 32'd16);

        // Backward branch
        jumpTo(32'h100);
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0, 32'h0, "br_back c1");
        check("br_back c1 pc const", pc, 32'h100);
        idle("br_back c2");
        check("br_back c2 pc const", pc, 32'h0FC);

        // Jump has priority over branch
        jumpTo(32'h100);
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 32'h2000, "jr_prio");
        check("jr_prio pc const", pc, 32'h2000);

        // Branch held by stall, with requests presented during the stall
        jumpTo(32'h40);
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 32'h0, "br_stall c1");
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b0, 32'h0, "br_stall s1");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 32'h9000, "br_stall s2");
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, "br_stall s3");
        check("br_stall s3 busy const", 32'(busy), 32'd1);
        idle("br_stall done");
        check("br_stall pc const", pc, 32'h84);

        // Requests during BR_CALC are dropped, not queued
        jumpTo(32'h200);
        applyStimulus(1'b0, 1'b1, 16'h0001, 1'b0, 32'h0, "ignore c1");
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1, 32'h5000, "ignore c2");
        check("ignore c2 pc const", pc, 32'h208);
        idle("ignore after");
        check("ignore after pc const", pc, 32'h20C);

        // Stall in RUN holds pc and drops requests
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 32'h0, "run_stall1");
        applyStimulus(1'b1, 1'b1, 16'h0004, 1'b1, 32'h7000, "run_stall2");
        check("run_stall pc const", pc, 32'h20C);

        // Wrap-around
        jumpTo(32'hFFFF_FFFC);
        idle("wrap seq");
        check("wrap seq pc const", pc, 32'h0);
        jumpTo(32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b1, 16'h7FFF, 1'b0, 32'h0, "wrap br c1");
        idle("wrap br c2");
        check("wrap br pc const", pc, 32'h0001_FFF8);

        // Misaligned jump target
        jumpTo(32'h20);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 32'h3002, "misalign");
`ifdef PC_ALIGN_CHECK_EN
        check("misalign pc const", pc, 32'h24);
        check("misalign err const", 32'(misalign_err), 32'd1);
        idle("misalign after");
        check("misalign err clear", 32'(misalign_err), 32'd0);
`else
        check("misalign pc const", pc, 32'h3002);
`endif

        // Reset while in BR_CALC aborts the branch
        jumpTo(32'h300);
        applyStimulus(1'b0, 1'b1, 16'h0004, 1'b0, 32'h0, "abort c1");
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("abort async");
        @(posedge clk);
        #1;
        checkOutput("abort held");
        rst_n = 1'b1;
        idle("abort release");
        check("abort release pc const", pc, RESET_PC + 32'd4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r_s   = ($urandom_range(0, 3) == 0);
            r_b   = ($urandom_range(0, 3) == 0);
            r_j   = ($urandom_range(0, 5) == 0);
            r_imm = 16'($urandom);
            r_t   = $urandom;
            if ($urandom_range(0, 3) != 0) r_t[1:0] = 2'b00;
            applyStimulus(r_s, r_b, r_imm, r_j, r_t, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  hold request; when 1, pc and state SHALL NOT change.
REQ-005 br_req  input  1  taken-branch request, sampled only when busy=0.
REQ-006 br_imm  input  16  branch word offset, two's complement.
REQ-007 jr_req  input  1  jump-register request, sampled only when busy=0.
REQ-008 jr_target  input  32  absolute jump target.
REQ-009 pc  output  32  current fetch address.
REQ-010 pc_valid  output  1  pc is a committed fetch address this cycle.
REQ-011 busy  output  1  branch target computation in progress; requests ignored.
REQ-012 misalign_err  output  1  one-cycle misaligned-jump flag; present only with PC_ALIGN_CHECK_EN.

Function
REQ-013 The block SHALL contain exactly one 32-bit adder, operands selected by state; sum width 32, carry-out discarded (modulo 2^32 wrap).
REQ-014 The FSM SHALL have two states: RUN and BR_CALC.
REQ-015 RUN: adder operands SHALL be pc and 32'd4; busy=0, pc_valid=1.
REQ-016 RUN, stall_i=1: pc, state and internal registers held; requests ignored.
REQ-017 RUN, stall_i=0, jr_req=1: pc <= jr_target next cycle, stay in RUN; jr_req has priority over br_req.
REQ-018 RUN, stall_i=0, br_req=1, jr_req=0: latch pc+4 into pc4_q, latch offset {{14{br_imm[15]}},br_imm,2'b00} into off_q, go to BR_CALC; pc unchanged.
REQ-019 RUN, stall_i=0, no request: pc <= pc+4.
REQ-020 BR_CALC: adder operands SHALL be pc4_q and off_q; busy=1, pc_valid=0.
REQ-021 BR_CALC, stall_i=0: pc <= pc4_q+off_q, go to RUN; branch latency two cycles from request to target on pc.
REQ-022 BR_CALC, stall_i=1: state, pc4_q, off_q, pc held.
REQ-023 br_req/jr_req asserted while busy=1 SHALL be ignored and not queued.
REQ-024 pc=32'hFFFF_FFFC with no request SHALL wrap to 32'h0000_0000.

Reset
REQ-025 On rst_n=0, immediately: pc=RESET_PC, state=RUN, pc4_q=0, off_q=0, busy=0, pc_valid=0, misalign_err=0.
REQ-026 pc_valid SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-027 Reset during BR_CALC SHALL abort the branch; no target is committed.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN: when defined, a jr_req accepted per REQ-017 with jr_target[1:0]!=0 SHALL not be taken; pc <= pc+4 and misalign_err=1 for exactly the next cycle.
REQ-029 Without PC_ALIGN_CHECK_EN: port misalign_err absent, jr_target loaded verbatim regardless of low bits.

Verification
REQ-030 Reset release, RESET_PC=0, no requests 4 cycles -> pc 0,4,8,12,16; pc_valid=1 from first edge.
REQ-031 pc=32'h100, br_req=1, br_imm=16'hFFFE -> cycle+1 busy=1 pc=32'h100; cycle+2 pc=32'h0FC, busy=0.
REQ-032 pc=32'h100, br_req=1 and jr_req=1, jr_target=32'h2000 -> next pc=32'h2000, busy stays 0.
REQ-033 BR_CALC with stall_i=1 for 3 cycles, br_imm=16'h0010 from pc=32'h40 -> busy held 3 cycles, then pc=32'h84.
REQ-034 pc=32'hFFFF_FFFC, no request -> pc=32'h0; br_req br_imm=16'h7FFF at pc=32'hFFFF_FFF8 -> pc=32'h0001_FFF8.
REQ-035 With PC_ALIGN_CHECK_EN, pc=32'h20, jr_req jr_target=32'h3002 -> pc=32'h24, misalign_err=1 one cycle; without macro -> pc=32'h3002.
